wb_slave_mem: RTL and testbench

- Wishbone classic-cycle slave memory with byte lanes.
- Sits directly downstream of the master-to-slave Wishbone interconnect and consumes its slave-side signals: CYC, STB, WE, ADR, DAT, SEL, LOCK, TGA, TGC and TGD.
- Answers every access with exactly one of ACK, ERR or RTY after a programmable number of wait states.
- Serves as the default target slave in the generic environment.

---
 rtl/wb_slave_pkg.sv | 13 +
 rtl/wb_slave_mem_array.sv | 27 ++
 rtl/wb_slave_mem.sv | 160 ++++++++++++++++
 tb/tb_wb_slave_mem.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_pkg.sv
// Shared types and helpers for the Wishbone slave memory.
package wb_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_e;

  // Byte-offset bits inside a DW-bit word, log2(DW/8).
  function automatic int off_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_slave_mem_array.sv
// DEPTH x DW storage, byte-lane write enables, registered read port.
module wb_slave_mem_array #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int MAW   = 8
) (
  input  logic              clk,
  input  logic [MAW-1:0]    addr,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);
  localparam int NB = DW / 8;

  logic [DW-1:0] mem [DEPTH];

  // Lane-masked write and unconditional registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave memory: FSM, address decode, tag echo.
// Optional macro WB_SLAVE_RTY_EN: every RTY_PERIOD-th in-range access that
// reaches the response cycle is terminated with RTY instead of ACK.
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int TGW         = 4,
  parameter int RTY_PERIOD  = 4
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [AW-1:0]     ADR_I,
  input  logic [DW-1:0]     DAT_I,
  input  logic [DW/8-1:0]   SEL_I,
  input  logic              LOCK_I,
  input  logic [TGW-1:0]    TGA_I,
  input  logic [TGW-1:0]    TGC_I,
  input  logic [TGW-1:0]    TGD_I,
  output logic [DW-1:0]     DAT_O,
  output logic [TGW-1:0]    TGD_O,
  output logic              ACK_O,
  output logic              ERR_O,
  output logic              RTY_O
);
  localparam int NB   = DW / 8;
  localparam int OFFW = off_bits(DW);
  localparam int IW   = AW - OFFW;
  localparam int MAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef struct packed {
    logic           we;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  dat;
    logic [NB-1:0]  sel;
    logic [TGW-1:0] tgd;
    logic           in_rng;
  } req_t;

  state_e         state, state_nxt;
  rsp_e           rsp, rsp_nxt, rsp_pick;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  req_t           cap;
  logic           capture, bus_req, dec_rng, rng_now, rty_hit;
  logic [IW-1:0]  dec_idx;
  logic [MAW-1:0] arr_addr;
  logic           arr_we;
  logic [DW-1:0]  rd_data;

  assign bus_req = CYC_I & STB_I;
  assign dec_idx = ADR_I[AW-1:OFFW];
  assign dec_rng = (64'(dec_idx) < 64'(DEPTH));
  // Range flag of the access about to enter RESP: live decode from IDLE,
  // captured flag from WAIT.
  assign rng_now = (state == IDLE) ? dec_rng : cap.in_rng;
  assign rsp_pick = !rng_now ? RSP_ERR : (rty_hit ? RSP_RTY : RSP_ACK);

`ifdef WB_SLAVE_RTY_EN
  localparam int RCW = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;
  logic [RCW-1:0] acc_cnt;

  assign rty_hit = (acc_cnt == RCW'(RTY_PERIOD - 1));

  // Count in-range accesses as they enter RESP; wrap on the retried one.
  always_ff @(posedge CLK_I) begin
    if (!RST_I)                               acc_cnt <= '0;
    else if (state_nxt == RESP && rng_now)    acc_cnt <= rty_hit ? '0 : acc_cnt + RCW'(1);
  end
`else
  assign rty_hit = 1'b0;
`endif

  // Next-state, wait counter and response selection.
  always_comb begin
    state_nxt = state;
    rsp_nxt   = rsp;
    wcnt_nxt  = wcnt;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus_req) begin
        capture = 1'b1;
        if (WAIT_STATES == 0) begin
          state_nxt = RESP;
          rsp_nxt   = rsp_pick;
        end else begin
          state_nxt = WAIT;
          wcnt_nxt  = WCW'(WAIT_STATES - 1);
        end
      end
      WAIT: begin
        if (!bus_req) state_nxt = IDLE;
        else if (wcnt == '0) begin
          state_nxt = RESP;
          rsp_nxt   = rsp_pick;
        end else wcnt_nxt = wcnt - WCW'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, response kind and wait counter registers.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state <= IDLE;
      rsp   <= RSP_ACK;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      rsp   <= rsp_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Request capture; only observed through state-gated outputs, so no reset.
  always_ff @(posedge CLK_I) begin
    if (capture) cap <= '{we: WE_I, idx: dec_idx, dat: DAT_I, sel: SEL_I,
                           tgd: TGD_I, in_rng: dec_rng};
  end

  // Read address comes straight from the bus in IDLE so zero-wait reads
  // have data in the response cycle. Reset at the RESP edge drops the write.
  assign arr_addr = MAW'((state == IDLE) ? dec_idx : cap.idx);
  assign arr_we   = (state == RESP) && (rsp == RSP_ACK) && cap.we && RST_I;

  wb_slave_mem_array #(.DW(DW), .DEPTH(DEPTH), .MAW(MAW)) u_array (
    .clk   (CLK_I),
    .addr  (arr_addr),
    .we    (arr_we),
    .be    (cap.sel),
    .wdata (cap.dat),
    .rdata (rd_data)
  );

  assign ACK_O = (state == RESP) && (rsp == RSP_ACK);
  assign ERR_O = (state == RESP) && (rsp == RSP_ERR);
`ifdef WB_SLAVE_RTY_EN
  assign RTY_O = (state == RESP) && (rsp == RSP_RTY);
`else
  assign RTY_O = 1'b0;
`endif
  assign DAT_O = (ACK_O && !cap.we) ? rd_data : '0;
  assign TGD_O = (state == RESP) ? cap.tgd : '0;

  // Accepted-but-ignored inputs and partially used fields.
  logic unused_ok;
`ifdef WB_SLAVE_RTY_EN
  assign unused_ok = ^{LOCK_I, TGA_I, TGC_I, ADR_I, cap};
`else
  assign unused_ok = ^{LOCK_I, TGA_I, TGC_I, ADR_I, cap, 1'(RTY_PERIOD)};
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem (WAIT_STATES=2, DEPTH=256, RTY_PERIOD=4).
module tb_wb_slave_mem;
  localparam logic [2:0] T_ACK = 3'b100, T_ERR = 3'b010, T_RTY = 3'b001;

  logic        CLK_I = 1'b0, RST_I = 1'b0;
  logic        CYC_I, STB_I, WE_I, LOCK_I;
  logic [31:0] ADR_I, DAT_I;
  logic [3:0]  SEL_I, TGA_I, TGC_I, TGD_I;
  logic [31:0] DAT_O;
  logic [3:0]  TGD_O;
  logic        ACK_O, ERR_O, RTY_O;

  always #5 CLK_I = ~CLK_I;

  wb_slave_mem #(.AW(32), .DW(32), .DEPTH(256), .WAIT_STATES(2), .TGW(4), .RTY_PERIOD(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .LOCK_I(LOCK_I), .TGA_I(TGA_I),
    .TGC_I(TGC_I), .TGD_I(TGD_I), .DAT_O(DAT_O), .TGD_O(TGD_O),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = '0; DAT_I = '0;
    SEL_I = '0; TGD_I = '0; TGA_I = '0; TGC_I = '0; LOCK_I = 0;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [3:0] tgd);
    CYC_I = 1; STB_I = 1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
    TGD_I = tgd; TGA_I = tgd ^ 4'h5; TGC_I = ~tgd; LOCK_I = we;
  endtask

  // One access: term/rdat/rtgd sampled in the terminator cycle, lat counted
  // in cycles after the request edge. With retry set, RTY is re-issued.
  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] tgd, input bit retry,
                        output logic [2:0] term, output logic [31:0] rdat,
                        output logic [3:0] rtgd, output int lat);
    int tries = 0;
    do begin
      @(negedge CLK_I);
      drive(we, adr, dat, sel, tgd);
      lat = 0; term = '0; rdat = '0; rtgd = '0;
      while (term == 3'b000 && lat < 20) begin
        @(negedge CLK_I);
        lat++;
        term = {ACK_O, ERR_O, RTY_O};
      end
      rdat = DAT_O; rtgd = TGD_O;
      CYC_I = 0; STB_I = 0;
      if (term == 3'b000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: no terminator within %0d cycles, want one", lat);
      end else begin
        @(negedge CLK_I);
        chk("pulse_width", {ACK_O, ERR_O, RTY_O}, 3'b000);
      end
      tries++;
    end while (retry && term == T_RTY && tries < 4);
  endtask

  task automatic do_reset();
    @(negedge CLK_I);
    RST_I = 0; idle_bus();
    repeat (2) @(negedge CLK_I);
    RST_I = 1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel, tgd;
    logic [2:0]  term;
    logic [31:0] rdat;
  } vec_t;

  vec_t        tbl[17];
  logic [2:0]  term, seen;
  logic [31:0] rdat;
  logic [3:0]  rtgd;
  int          lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 4'h1, T_ACK, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'hF, 4'h2, T_ACK, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h10,       32'h0000AA00, 4'h2, 4'h3, T_ACK, 32'h0};
    tbl[3]  = '{1'b0, 32'h10,       32'h0,        4'hF, 4'h4, T_ACK, 32'hDEADAAEF};
    tbl[4]  = '{1'b0, 32'h400,      32'h0,        4'hF, 4'h5, T_ERR, 32'h0};
    tbl[5]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 4'h6, T_ACK, 32'h0};
    tbl[6]  = '{1'b1, 32'h400,      32'h11111111, 4'hF, 4'h7, T_ERR, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,        32'h0,        4'hF, 4'h8, T_ACK, 32'hCAFEF00D};
    tbl[8]  = '{1'b0, 32'h10,       32'h0,        4'hF, 4'h9, T_ACK, 32'hDEADAAEF};
    tbl[9]  = '{1'b1, 32'h13,       32'h55000000, 4'h8, 4'hA, T_ACK, 32'h0};
    tbl[10] = '{1'b0, 32'h12,       32'h0,        4'hF, 4'hB, T_ACK, 32'h55ADAAEF};
    tbl[11] = '{1'b1, 32'h20,       32'hA5A5A5A5, 4'hF, 4'hC, T_ACK, 32'h0};
    tbl[12] = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 4'hD, T_ACK, 32'h0};
    tbl[13] = '{1'b0, 32'h20,       32'h0,        4'hF, 4'hE, T_ACK, 32'hA5A5A5A5};
    tbl[14] = '{1'b1, 32'h3FC,      32'h01020304, 4'hF, 4'hF, T_ACK, 32'h0};
    tbl[15] = '{1'b0, 32'h3FF,      32'h0,        4'hF, 4'h0, T_ACK, 32'h01020304};
    tbl[16] = '{1'b0, 32'hFFFFFFF0, 32'h0,        4'hF, 4'h1, T_ERR, 32'h0};

    // Reset state
    idle_bus();
    RST_I = 0;
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_ack", ACK_O, 1'b0);
    chk("rst_err", ERR_O, 1'b0);
    chk("rst_rty", RTY_O, 1'b0);
    chk("rst_dat", DAT_O, 32'h0);
    chk("rst_tgd", TGD_O, 4'h0);
    RST_I = 1;

    // Table: term, data, tag echo and latency (3 cycles for WAIT_STATES=2)
    for (int i = 0; i < 17; i++) begin
      access(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].tgd, 1'b1,
             term, rdat, rtgd, lat);
      chk($sformatf("v%0d_term", i), term, tbl[i].term);
      chk($sformatf("v%0d_dat", i),  rdat, tbl[i].rdat);
      chk($sformatf("v%0d_tgd", i),  rtgd, tbl[i].tgd);
      chk($sformatf("v%0d_lat", i),  lat,  3);
    end

    // Abort: STB drops during WAIT of a write to 0x20
    @(negedge CLK_I);
    drive(1'b1, 32'h20, 32'h12345678, 4'hF, 4'h3);
    @(negedge CLK_I);
    CYC_I = 0; STB_I = 0;
    seen = '0;
    repeat (5) begin
      @(negedge CLK_I);
      seen = seen | {ACK_O, ERR_O, RTY_O};
    end
    chk("abort_term", seen, 3'b000);
    access(1'b0, 32'h20, 32'h0, 4'hF, 4'h4, 1'b1, term, rdat, rtgd, lat);
    chk("abort_rd", rdat, 32'hA5A5A5A5);

    // Reset during WAIT of a write
    @(negedge CLK_I);
    drive(1'b1, 32'h20, 32'h0BADBEEF, 4'hF, 4'h6);
    @(negedge CLK_I);
    RST_I = 0; idle_bus();
    @(negedge CLK_I);
    chk("rstw_term", {ACK_O, ERR_O, RTY_O}, 3'b000);
    chk("rstw_dat", DAT_O, 32'h0);
    chk("rstw_tgd", TGD_O, 4'h0);
    RST_I = 1;
    access(1'b0, 32'h20, 32'h0, 4'hF, 4'h7, 1'b0, term, rdat, rtgd, lat);
    chk("rstw_term_after", term, T_ACK);
    chk("rstw_rd", rdat, 32'hA5A5A5A5);

    // Reset coinciding with the response cycle of a write
    @(negedge CLK_I);
    drive(1'b1, 32'h20, 32'h0BADF00D, 4'hF, 4'h9);
    lat = 0; term = '0;
    while (term == 3'b000 && lat < 20) begin
      @(negedge CLK_I);
      lat++;
      term = {ACK_O, ERR_O, RTY_O};
    end
    chk("rstr_term", term, T_ACK);
    RST_I = 0; idle_bus();
    @(negedge CLK_I);
    chk("rstr_after", {ACK_O, ERR_O, RTY_O}, 3'b000);
    RST_I = 1;
    access(1'b0, 32'h20, 32'h0, 4'hF, 4'hA, 1'b1, term, rdat, rtgd, lat);
    chk("rstr_rd", rdat, 32'hA5A5A5A5);

    // Eight reads with tags 0..7 from a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  et;
      logic [31:0] ed;
`ifdef WB_SLAVE_RTY_EN
      et = ((i % 4) == 3) ? T_RTY : T_ACK;
`else
      et = T_ACK;
`endif
      ed = (et == T_ACK) ? 32'h55ADAAEF : 32'h0;
      access(1'b0, 32'h10, 32'h0, 4'hF, 4'(i), 1'b0, term, rdat, rtgd, lat);
      chk($sformatf("r%0d_term", i), term, et);
      chk($sformatf("r%0d_dat", i),  rdat, ed);
      chk($sformatf("r%0d_tgd", i),  rtgd, 4'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
